// File: rtl/pipelined_barrel_shifter.sv
// rtl/pipelined_barrel_shifter.sv - pipelined LSL/LSR/ASR/ROR/ROL shifter with valid/ready handshake
// log2(N) mux levels spread over PIPE_STAGES registers; carry travels with the data.
module pipelined_barrel_shifter #(
  parameter int N           = 32,
  parameter int PIPE_STAGES = 2,
  parameter int TAG_W       = 4
) (
  input  logic                 Clock,
  input  logic                 Reset,
  input  logic                 In_Valid,
  output logic                 In_Ready,
  input  logic [N-1:0]         Input,
  input  logic [$clog2(N)-1:0] Shift_Val,
  input  logic [2:0]           Mode,
  input  logic [TAG_W-1:0]     Tag,
  output logic                 Out_Valid,
  input  logic                 Out_Ready,
  output logic [N-1:0]         Result,
  output logic                 Carry_Out,
  output logic                 Zero,
  output logic                 Illegal,
  output logic [TAG_W-1:0]     Tag_Out
);

  localparam int L = $clog2(N);

  localparam logic [2:0] MODE_LSL = 3'b000;
  localparam logic [2:0] MODE_LSR = 3'b001;
  localparam logic [2:0] MODE_ASR = 3'b010;
  localparam logic [2:0] MODE_ROR = 3'b011;
  localparam logic [2:0] MODE_ROL = 3'b100;

  typedef struct packed {
    logic             valid;
    logic [N-1:0]     data;
    logic [L-1:0]     shamt;
    logic [2:0]       mode;
    logic [TAG_W-1:0] tag;
    logic             carry;
  } stage_t;

  stage_t in_st;
  stage_t cur_st;
  stage_t stage_d [PIPE_STAGES];
  stage_t stage_q [PIPE_STAGES];
  logic   advance;

  // Level index j runs from the largest shift (j=0, amount N/2) to the smallest.
  function automatic int stage_of(input int j);
    return (j * PIPE_STAGES) / L;
  endfunction

  function automatic stage_t apply_level(input stage_t st, input int k);
    stage_t r;
    int     amt;
    logic   lo_bit;
    logic   hi_bit;
    r      = st;
    amt    = 1 << k;
    lo_bit = |(st.data & (N'(1) << (amt - 1)));
    hi_bit = |(st.data & (N'(1) << (N - amt)));
    if (|(st.shamt & (L'(1) << k))) begin
      case (st.mode)
        MODE_LSL: begin r.data = st.data << amt;                               r.carry = hi_bit; end
        MODE_LSR: begin r.data = st.data >> amt;                               r.carry = lo_bit; end
        MODE_ASR: begin r.data = $signed(st.data) >>> amt;                     r.carry = lo_bit; end
        MODE_ROR: begin r.data = (st.data >> amt) | (st.data << (N - amt));    r.carry = lo_bit; end
        MODE_ROL: begin r.data = (st.data << amt) | (st.data >> (N - amt));    r.carry = hi_bit; end
        default: ;
      endcase
    end
    return r;
  endfunction

  assign in_st = '{valid: In_Valid, data: Input, shamt: Shift_Val, mode: Mode, tag: Tag, carry: 1'b0};

  // Each stage consumes the previous stage's register; stage 0 consumes the ports.
  always_comb begin
    cur_st = in_st;
    for (int s = 0; s < PIPE_STAGES; s++) begin
      for (int j = 0; j < L; j++) begin
        if (stage_of(j) == s) cur_st = apply_level(cur_st, L - 1 - j);
      end
      stage_d[s] = cur_st;
      cur_st     = stage_q[s];
    end
  end

  assign advance  = Out_Ready | ~stage_q[PIPE_STAGES-1].valid;
  assign In_Ready = advance;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int s = 0; s < PIPE_STAGES; s++) stage_q[s] <= '0;
    end else if (advance) begin
      for (int s = 0; s < PIPE_STAGES; s++) stage_q[s] <= stage_d[s];
    end
  end

  assign Out_Valid = stage_q[PIPE_STAGES-1].valid;
  assign Result    = stage_q[PIPE_STAGES-1].data;
  assign Carry_Out = stage_q[PIPE_STAGES-1].carry;
  assign Tag_Out   = stage_q[PIPE_STAGES-1].tag;
  assign Illegal   = stage_q[PIPE_STAGES-1].valid & (stage_q[PIPE_STAGES-1].mode > MODE_ROL);
  assign Zero      = stage_q[PIPE_STAGES-1].valid & (stage_q[PIPE_STAGES-1].data == '0);

endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
// tb/tb_pipelined_barrel_shifter.sv - self-checking bench for pipelined_barrel_shifter
// Directed table and sequences on N=8/3 stages, plus random sweeps over other configurations.
module tb_pipelined_barrel_shifter;

  typedef struct {
    logic [31:0] result;
    logic        carry;
    logic        zero;
    logic        ill;
    logic [3:0]  tag;
  } exp_t;

  typedef struct {
    logic [2:0] mode;
    logic [2:0] sh;
    logic [7:0] din;
    logic [7:0] res;
    logic       c;
    logic       z;
    logic       ill;
  } vec_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int pops = 0;
  int sweeps_finished = 0;

  logic       rst, in_valid, in_ready, out_valid, out_ready, carry, zero, ill;
  logic [7:0] data_in, result;
  logic [2:0] shift, mode;
  logic [3:0] tag, tag_out;

  exp_t q[$];
  exp_t pending;
  vec_t vecs [21];

  pipelined_barrel_shifter #(.N(8), .PIPE_STAGES(3), .TAG_W(4)) u_dut (
    .Clock(clk), .Reset(rst), .In_Valid(in_valid), .In_Ready(in_ready),
    .Input(data_in), .Shift_Val(shift), .Mode(mode), .Tag(tag),
    .Out_Valid(out_valid), .Out_Ready(out_ready), .Result(result),
    .Carry_Out(carry), .Zero(zero), .Illegal(ill), .Tag_Out(tag_out)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  task automatic mark_done();
    sweeps_finished++;
  endtask

  function automatic logic bit_at(input logic [31:0] v, input int i);
    logic [31:0] t;
    t = v >> i;
    return t[0];
  endfunction

  // Reference: each result bit is picked from its source bit position.
  function automatic exp_t model(input int n, input logic [31:0] din, input int s,
                                 input logic [2:0] m, input logic [3:0] t);
    exp_t e;
    int   src;
    logic b;
    e.result = '0;
    e.tag    = t;
    e.ill    = (m > 3'd4);
    for (int i = 0; i < n; i++) begin
      case (m)
        3'd0: begin src = i - s; b = (src >= 0) ? bit_at(din, src) : 1'b0; end
        3'd1: begin src = i + s; b = (src < n) ? bit_at(din, src) : 1'b0; end
        3'd2: begin src = i + s; b = (src < n) ? bit_at(din, src) : bit_at(din, n - 1); end
        3'd3: b = bit_at(din, (i + s) % n);
        3'd4: b = bit_at(din, (i - s + n) % n);
        default: b = bit_at(din, i);
      endcase
      if (b) e.result = e.result | (32'd1 << i);
    end
    e.carry = 1'b0;
    if (s != 0) begin
      case (m)
        3'd0:       e.carry = bit_at(din, n - s);
        3'd1, 3'd2: e.carry = bit_at(din, s - 1);
        3'd3:       e.carry = bit_at(e.result, n - 1);
        3'd4:       e.carry = e.result[0];
        default:    e.carry = 1'b0;
      endcase
    end
    e.zero = (e.result == 32'd0);
    return e;
  endfunction

  task automatic drive(input logic v, input logic [2:0] m, input logic [2:0] s,
                       input logic [7:0] d, input logic [3:0] t);
    in_valid = v; mode = m; shift = s; data_in = d; tag = t;
    pending  = model(8, {24'h0, d}, int'(s), m, t);
  endtask

  // Handshake bookkeeping, called a little after the negedge; ends on the next negedge.
  task automatic book();
    exp_t e;
    if (rst) begin
      q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_output: got tag %0h, expected no output", tag_out);
        end else begin
          e = q.pop_front();
          pops++;
          chk("result", {24'h0, result}, e.result);
          chk("carry", {31'h0, carry}, {31'h0, e.carry});
          chk("zero", {31'h0, zero}, {31'h0, e.zero});
          chk("illegal", {31'h0, ill}, {31'h0, e.ill});
          chk("tag_out", {28'h0, tag_out}, {28'h0, e.tag});
        end
      end
      if (in_valid && in_ready) q.push_back(pending);
    end
    @(negedge clk);
  endtask

  task automatic sb_step();
    #1;
    book();
  endtask

  task automatic drain(input string name);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 20 && q.size() != 0; i++) sb_step();
    chk(name, q.size(), 0);
  endtask

  localparam int NCFG = 5;
  localparam int CFG_N [NCFG] = '{8, 8, 32, 32, 32};
  localparam int CFG_P [NCFG] = '{1, 2, 1, 3, 5};

  for (genvar g = 0; g < NCFG; g++) begin : g_sweep
    localparam int NN = CFG_N[g];
    localparam int PP = CFG_P[g];
    localparam int SW = $clog2(NN);

    logic          s_rst, s_iv, s_ir, s_ov, s_or, s_c, s_z, s_il;
    logic [NN-1:0] s_din, s_res;
    logic [SW-1:0] s_sh;
    logic [2:0]    s_mode;
    logic [3:0]    s_tag, s_tago;
    exp_t          sq[$];
    exp_t          s_pend;

    pipelined_barrel_shifter #(.N(NN), .PIPE_STAGES(PP), .TAG_W(4)) u_sdut (
      .Clock(clk), .Reset(s_rst), .In_Valid(s_iv), .In_Ready(s_ir),
      .Input(s_din), .Shift_Val(s_sh), .Mode(s_mode), .Tag(s_tag),
      .Out_Valid(s_ov), .Out_Ready(s_or), .Result(s_res),
      .Carry_Out(s_c), .Zero(s_z), .Illegal(s_il), .Tag_Out(s_tago)
    );

    task automatic s_book();
      exp_t e;
      #1;
      if (s_ov && s_or) begin
        if (sq.size() == 0) begin
          checks++; errors++;
          $display("FAIL sweep%0d_unexpected: got tag %0h, expected no output", g, s_tago);
        end else begin
          e = sq.pop_front();
          chk($sformatf("sweep%0d_result", g), 32'(s_res), e.result);
          chk($sformatf("sweep%0d_carry", g), {31'h0, s_c}, {31'h0, e.carry});
          chk($sformatf("sweep%0d_zero", g), {31'h0, s_z}, {31'h0, e.zero});
          chk($sformatf("sweep%0d_illegal", g), {31'h0, s_il}, {31'h0, e.ill});
          chk($sformatf("sweep%0d_tag", g), {28'h0, s_tago}, {28'h0, e.tag});
        end
      end
      if (s_iv && s_ir) sq.push_back(s_pend);
      @(negedge clk);
    endtask

    initial begin
      s_rst = 1'b1; s_iv = 1'b0; s_or = 1'b1;
      s_din = '0; s_sh = '0; s_mode = 3'd0; s_tag = 4'd0;
      s_pend = model(NN, 32'd0, 0, 3'd0, 4'd0);
      repeat (2) @(negedge clk);
      s_rst = 1'b0;
      for (int c = 0; c < 600; c++) begin
        s_iv   = ($urandom_range(0, 3) != 0);
        s_or   = ($urandom_range(0, 4) != 0);
        s_mode = 3'($urandom_range(0, 7));
        s_sh   = SW'($urandom);
        s_din  = NN'($urandom);
        s_tag  = 4'($urandom);
        s_pend = model(NN, 32'(s_din), int'(s_sh), s_mode, s_tag);
        s_book();
      end
      s_iv = 1'b0;
      s_or = 1'b1;
      for (int i = 0; i < 30 && sq.size() != 0; i++) s_book();
      chk($sformatf("sweep%0d_drain", g), sq.size(), 0);
      mark_done();
    end
  end

  initial begin
    int   next, pops0, c;
    logic accepted;
    logic [7:0] snap_res;
    logic [3:0] snap_tag;

    vecs = '{
      '{3'd0, 3'd1, 8'h81, 8'h02, 1'b1, 1'b0, 1'b0},
      '{3'd2, 3'd3, 8'h80, 8'hF0, 1'b0, 1'b0, 1'b0},
      '{3'd1, 3'd3, 8'h80, 8'h10, 1'b0, 1'b0, 1'b0},
      '{3'd1, 3'd4, 8'h08, 8'h00, 1'b1, 1'b1, 1'b0},
      '{3'd3, 3'd1, 8'h01, 8'h80, 1'b1, 1'b0, 1'b0},
      '{3'd4, 3'd4, 8'h81, 8'h18, 1'b0, 1'b0, 1'b0},
      '{3'd0, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{3'd1, 3'd0, 8'hA5, 8'hA5, 1'b0, 1'b0, 1'b0},
      '{3'd2, 3'd0, 8'h80, 8'h80, 1'b0, 1'b0, 1'b0},
      '{3'd3, 3'd0, 8'h3C, 8'h3C, 1'b0, 1'b0, 1'b0},
      '{3'd4, 3'd0, 8'hC3, 8'hC3, 1'b0, 1'b0, 1'b0},
      '{3'd6, 3'd3, 8'h5A, 8'h5A, 1'b0, 1'b0, 1'b1},
      '{3'd5, 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b0, 1'b1},
      '{3'd7, 3'd2, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1},
      '{3'd0, 3'd7, 8'h03, 8'h80, 1'b1, 1'b0, 1'b0},
      '{3'd1, 3'd7, 8'h80, 8'h01, 1'b0, 1'b0, 1'b0},
      '{3'd2, 3'd7, 8'hC0, 8'hFF, 1'b1, 1'b0, 1'b0},
      '{3'd3, 3'd3, 8'h96, 8'hD2, 1'b1, 1'b0, 1'b0},
      '{3'd4, 3'd7, 8'h02, 8'h01, 1'b1, 1'b0, 1'b0},
      '{3'd3, 3'd7, 8'h02, 8'h04, 1'b0, 1'b0, 1'b0},
      '{3'd0, 3'd1, 8'h80, 8'h00, 1'b1, 1'b1, 1'b0}
    };

    rst = 1'b1; out_ready = 1'b1;
    drive(1'b0, 3'd0, 3'd0, 8'h00, 4'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("reset_out_valid", {31'h0, out_valid}, 32'd0);
    chk("reset_result", {24'h0, result}, 32'd0);
    chk("reset_carry", {31'h0, carry}, 32'd0);
    chk("reset_zero", {31'h0, zero}, 32'd0);
    chk("reset_illegal", {31'h0, ill}, 32'd0);
    chk("reset_tag_out", {28'h0, tag_out}, 32'd0);
    chk("reset_in_ready", {31'h0, in_ready}, 32'd1);
    @(negedge clk);

    // Latency: LSL 0x81 by 1 must surface exactly 3 cycles after acceptance.
    drive(1'b1, 3'd0, 3'd1, 8'h81, 4'd5);
    #1;
    chk("lat_in_ready", {31'h0, in_ready}, 32'd1);
    book();
    in_valid = 1'b0;
    for (c = 1; c <= 3; c++) begin
      #1;
      chk($sformatf("lat_out_valid_c%0d", c), {31'h0, out_valid}, {31'h0, c == 3});
      if (c == 3) begin
        chk("lat_result", {24'h0, result}, 32'h02);
        chk("lat_carry", {31'h0, carry}, 32'd1);
      end
      book();
    end

    for (int i = 0; i < 21; i++) begin
      drive(1'b1, vecs[i].mode, vecs[i].sh, vecs[i].din, 4'(i));
      pending = '{result: {24'h0, vecs[i].res}, carry: vecs[i].c, zero: vecs[i].z,
                  ill: vecs[i].ill, tag: 4'(i)};
      sb_step();
    end
    drain("table_drain");

    // Back-to-back tags 1..6 with Out_Ready low for cycles 4..6.
    next  = 1;
    pops0 = pops;
    for (c = 0; c < 40 && (next <= 6 || q.size() != 0); c++) begin
      out_ready = !(c >= 4 && c <= 6);
      if (next <= 6) drive(1'b1, 3'(next % 5), 3'(next), 8'(8'h3C + next), 4'(next));
      else in_valid = 1'b0;
      #1;
      if (c == 4) begin
        snap_res = result;
        snap_tag = tag_out;
        chk("stall_out_valid", {31'h0, out_valid}, 32'd1);
      end
      if (c >= 4 && c <= 6) chk($sformatf("stall_in_ready_c%0d", c), {31'h0, in_ready}, 32'd0);
      if (c == 5 || c == 6) begin
        chk($sformatf("stall_hold_result_c%0d", c), {24'h0, result}, {24'h0, snap_res});
        chk($sformatf("stall_hold_tag_c%0d", c), {28'h0, tag_out}, {28'h0, snap_tag});
      end
      accepted = in_valid && in_ready;
      book();
      if (accepted) next++;
    end
    chk("stall_emitted", pops - pops0, 6);
    drain("stall_drain");

    // Reset with three operations in flight, output stalled so none is emitted.
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 3'd0, 3'd1, 8'h11, 4'(9 + i));
      sb_step();
    end
    in_valid = 1'b0; out_ready = 1'b0; rst = 1'b1;
    #1;
    chk("inflight_out_valid", {31'h0, out_valid}, 32'd1);
    book();
    rst = 1'b0; out_ready = 1'b1;
    #1;
    chk("rst_mid_out_valid", {31'h0, out_valid}, 32'd0);
    chk("rst_mid_result", {24'h0, result}, 32'd0);
    chk("rst_mid_carry", {31'h0, carry}, 32'd0);
    chk("rst_mid_zero", {31'h0, zero}, 32'd0);
    chk("rst_mid_illegal", {31'h0, ill}, 32'd0);
    chk("rst_mid_tag_out", {28'h0, tag_out}, 32'd0);
    chk("rst_mid_in_ready", {31'h0, in_ready}, 32'd1);
    book();
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("post_rst_idle_%0d", i), {31'h0, out_valid}, 32'd0);
      book();
    end

    for (int i = 0; i < 300; i++) begin
      out_ready = ($urandom_range(0, 3) != 0);
      drive($urandom_range(0, 3) != 0, 3'($urandom_range(0, 7)), 3'($urandom),
            8'($urandom), 4'($urandom));
      sb_step();
    end
    drain("random_drain");

    for (int i = 0; i < 20000 && sweeps_finished < NCFG; i++) @(negedge clk);
    chk("sweeps_finished", sweeps_finished, NCFG);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
